psm_phase_gen: RTL and testbench

Phase-shift modulation carrier generator for the dual-bridge converter. It produces two 50 %-duty square waves: a primary leg and a secondary leg delayed by a programmable signed phase. It also passes a deadtime count to the downstream psm_deadtime stages.
Each output bit drives the iPSM input of one deadtime stage, and oDT drives that stage's iSHIFT. New configurations are double-buffered and only take effect on a period boundary.

---
 rtl/psm_pkg.sv | 18 +
 rtl/psm_phase_cfg.sv | 68 ++++++
 rtl/psm_phase_gen.sv | 134 +++++++++++++
 tb/tb_psm_phase_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psm_pkg.sv
// rtl/psm_pkg.sv - shared state type, default sizes and clamp helper for the PSM phase generator
package psm_pkg;

    localparam int DEF_CNT_BITS   = 12;
    localparam int DEF_DT_BITS    = 7;
    localparam int DEF_PERIOD_MIN = 8;

    typedef enum logic [0:0] {
        PSM_IDLE = 1'b0,
        PSM_RUN  = 1'b1
    } psm_state_e;

    // Largest phase magnitude that keeps the secondary edge strictly inside a half period (H-1).
    function automatic int unsigned clamp_limit(input int unsigned period);
        return (period >> 1) - 1;
    endfunction

endpackage

// File: rtl/psm_phase_cfg.sv
// rtl/psm_phase_cfg.sv - shadow configuration: period rounding, range check, phase clamp, pending/error flags
module psm_phase_cfg
    import psm_pkg::*;
#(
    parameter int CNT_BITS   = DEF_CNT_BITS,
    parameter int DT_BITS    = DEF_DT_BITS,
    parameter int PERIOD_MIN = DEF_PERIOD_MIN
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       load,
    input  logic                       apply,
    input  logic [CNT_BITS-1:0]        period,
    input  logic [CNT_BITS-1:0]        phase,
    input  logic [DT_BITS-1:0]         dt,
    output logic [CNT_BITS-1:0]        cfg_period,
    output logic signed [CNT_BITS:0]   cfg_phase,
    output logic [DT_BITS-1:0]         cfg_dt,
    output logic                       cfg_valid,
    output logic                       pend,
    output logic                       err
);

    logic [CNT_BITS-1:0]      per_even;
    logic                     per_ok;
    logic signed [CNT_BITS:0] ph_ext;
    logic signed [CNT_BITS:0] lim;
    logic signed [CNT_BITS:0] ph_clamped;

    // Round the period down to even, range-check it and clamp the sign-extended phase to +/-(H-1).
    always_comb begin
        per_even   = period & ~CNT_BITS'(1);
        per_ok     = per_even >= CNT_BITS'(PERIOD_MIN);
        lim        = $signed((CNT_BITS+1)'(clamp_limit(32'(per_even))));
        ph_ext     = $signed({phase[CNT_BITS-1], phase});
        ph_clamped = ph_ext;
        if (ph_ext > lim) begin
            ph_clamped = lim;
        end else if (ph_ext < -lim) begin
            ph_clamped = -lim;
        end
    end

    // Shadow capture; an apply in the same cycle as a good load consumes the old shadow, the new one stays pending.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cfg_period <= '0;
            cfg_phase  <= '0;
            cfg_dt     <= '0;
            cfg_valid  <= 1'b0;
            pend       <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= load && !per_ok;
            if (apply) begin
                pend <= 1'b0;
            end
            if (load && per_ok) begin
                cfg_period <= per_even;
                cfg_phase  <= ph_clamped;
                cfg_dt     <= dt;
                cfg_valid  <= 1'b1;
                pend       <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/psm_phase_gen.sv
// rtl/psm_phase_gen.sv - phase-shift modulation carrier generator with double-buffered configuration
module psm_phase_gen
    import psm_pkg::*;
#(
    parameter int CNT_BITS   = DEF_CNT_BITS,
    parameter int DT_BITS    = DEF_DT_BITS,
    parameter int PERIOD_MIN = DEF_PERIOD_MIN
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                iEN,
    input  logic                iLOAD,
    input  logic [CNT_BITS-1:0] iPERIOD,
    input  logic [CNT_BITS-1:0] iPHASE,
    input  logic [DT_BITS-1:0]  iDT,
    output logic                oPSM_P,
    output logic                oPSM_S,
    output logic [DT_BITS-1:0]  oDT,
    output logic                oSYNC,
    output logic                oPEND,
    output logic                oERR
);

    localparam logic [0:0]            S_IDLE = PSM_IDLE;
    localparam logic [0:0]            S_RUN  = PSM_RUN;
    localparam logic [CNT_BITS-1:0]   ONE    = CNT_BITS'(1);
    localparam logic [CNT_BITS:0]     ONE_S  = (CNT_BITS+1)'(1);

    logic [0:0]               state;
    logic [CNT_BITS-1:0]      cnt;
    logic [CNT_BITS:0]        cnt_s;
    logic [CNT_BITS-1:0]      act_p;
    logic signed [CNT_BITS:0] act_phi;

    logic [CNT_BITS-1:0]      cfg_period;
    logic signed [CNT_BITS:0] cfg_phase;
    logic [DT_BITS-1:0]       cfg_dt;
    logic                     cfg_valid;
    logic                     pend;
    logic                     err;

    logic                     is_run;
    logic                     wrap;
    logic                     start;
    logic                     apply;
    logic [CNT_BITS-1:0]      half;
    logic [CNT_BITS:0]        last_s;
    logic [CNT_BITS-1:0]      nxt_p;
    logic signed [CNT_BITS:0] nxt_phi;
    logic signed [CNT_BITS:0] cnt_s_init;

    psm_phase_cfg #(
        .CNT_BITS   (CNT_BITS),
        .DT_BITS    (DT_BITS),
        .PERIOD_MIN (PERIOD_MIN)
    ) u_cfg (
        .CLK        (CLK),
        .RST        (RST),
        .load       (iLOAD),
        .apply      (apply),
        .period     (iPERIOD),
        .phase      (iPHASE),
        .dt         (iDT),
        .cfg_period (cfg_period),
        .cfg_phase  (cfg_phase),
        .cfg_dt     (cfg_dt),
        .cfg_valid  (cfg_valid),
        .pend       (pend),
        .err        (err)
    );

    assign oPEND = pend;
    assign oERR  = err;

    // Period boundary detection, apply decision and the (-phi mod P) start value of the secondary counter.
    always_comb begin
        is_run     = state == S_RUN;
        wrap       = is_run && (cnt == act_p - ONE);
        start      = !is_run && iEN && cfg_valid;
        apply      = start || (wrap && iEN && pend);
        half       = act_p >> 1;
        last_s     = {1'b0, act_p - ONE};
        nxt_p      = apply ? cfg_period : act_p;
        nxt_phi    = apply ? cfg_phase : act_phi;
        cnt_s_init = -nxt_phi;
        if (cnt_s_init < 0) begin
            cnt_s_init = cnt_s_init + $signed({1'b0, nxt_p});
        end
    end

    // Counters, IDLE/RUN sequencing, active configuration and registered waveforms.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            cnt_s   <= '0;
            act_p   <= '0;
            act_phi <= '0;
            oDT     <= '1;
            oPSM_P  <= 1'b0;
            oPSM_S  <= 1'b0;
            oSYNC   <= 1'b0;
        end else begin
            oPSM_P <= is_run && (cnt < half);
            oPSM_S <= is_run && (cnt_s < {1'b0, half});
            oSYNC  <= is_run && (cnt == '0);
            if (apply) begin
                act_p   <= cfg_period;
                act_phi <= cfg_phase;
                oDT     <= cfg_dt;
            end
            if (!is_run) begin
                cnt   <= '0;
                cnt_s <= '0;
                if (start) begin
                    state <= S_RUN;
                    cnt_s <= cnt_s_init;
                end
            end else if (wrap) begin
                cnt <= '0;
                if (!iEN) begin
                    state <= S_IDLE;
                    cnt_s <= '0;
                end else begin
                    cnt_s <= cnt_s_init;
                end
            end else begin
                cnt   <= cnt + ONE;
                cnt_s <= (cnt_s == last_s) ? '0 : cnt_s + ONE_S;
            end
        end
    end

endmodule

// File: tb/tb_psm_phase_gen.sv
// tb/tb_psm_phase_gen.sv - self-checking bench for psm_phase_gen against a behavioural carrier model
module tb_psm_phase_gen;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iEN = 1'b0;
    logic        iLOAD = 1'b0;
    logic [11:0] iPERIOD = '0;
    logic [11:0] iPHASE = '0;
    logic [6:0]  iDT = '0;
    logic        oPSM_P;
    logic        oPSM_S;
    logic [6:0]  oDT;
    logic        oSYNC;
    logic        oPEND;
    logic        oERR;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;

    // behavioural model state
    bit m_run = 0;
    int m_pos = 0;
    int m_P = 0;
    int m_phi = 0;
    int m_dt = 127;
    bit m_pend = 0;
    bit s_valid = 0;
    int s_P = 0;
    int s_phi = 0;
    int s_dt = 0;

    // edge measurement from DUT outputs
    bit prev_p = 0;
    bit prev_s = 0;
    int last_rise_p = 0;
    int last_rise_s = 0;
    int last_sync = 0;
    int lag = -1;
    int lead = -1;
    int sync_gap = -1;

    psm_phase_gen #(
        .CNT_BITS   (12),
        .DT_BITS    (7),
        .PERIOD_MIN (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iEN     (iEN),
        .iLOAD   (iLOAD),
        .iPERIOD (iPERIOD),
        .iPHASE  (iPHASE),
        .iDT     (iDT),
        .oPSM_P  (oPSM_P),
        .oPSM_S  (oPSM_S),
        .oDT     (oDT),
        .oSYNC   (oSYNC),
        .oPEND   (oPEND),
        .oERR    (oERR)
    );

    always #5 CLK = ~CLK;

    function automatic int md(input int a, input int b);
        return ((a % b) + b) % b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic apply_shadow();
        m_P = s_P;
        m_phi = s_phi;
        m_dt = s_dt;
        m_pend = 0;
    endtask

    task automatic step(input bit rst, input bit en, input bit ld, input int per, input int ph, input int dt);
        logic [11:0] per12;
        logic signed [11:0] ph12;
        logic [6:0] dt7;
        int pe, lim, cph;
        bit ep, es, esy, eer;
        per12 = per[11:0];
        ph12 = ph[11:0];
        dt7 = dt[6:0];
        @(negedge CLK);
        RST = rst;
        iEN = en;
        iLOAD = ld;
        iPERIOD = per12;
        iPHASE = ph12;
        iDT = dt7;
        @(posedge CLK);
        #1;
        cyc++;
        if (rst) begin
            m_run = 0; m_pos = 0; m_P = 0; m_phi = 0; m_dt = 127;
            m_pend = 0; s_valid = 0; s_P = 0; s_phi = 0; s_dt = 0;
            ep = 0; es = 0; esy = 0; eer = 0;
        end else begin
            ep  = m_run && (m_pos < m_P / 2);
            es  = m_run && (md(m_pos - m_phi, m_P) < m_P / 2);
            esy = m_run && (m_pos == 0);
            pe  = int'(per12) & ~1;
            eer = ld && (pe < 8);
            if (!m_run) begin
                if (en && s_valid) begin
                    apply_shadow();
                    m_run = 1;
                    m_pos = 0;
                end
            end else if (m_pos == m_P - 1) begin
                if (!en) m_run = 0;
                else if (m_pend) apply_shadow();
                m_pos = 0;
            end else begin
                m_pos++;
            end
            if (ld && pe >= 8) begin
                lim = pe / 2 - 1;
                cph = int'(ph12);
                if (cph > lim) cph = lim;
                if (cph < -lim) cph = -lim;
                s_P = pe; s_phi = cph; s_dt = int'(dt7);
                s_valid = 1;
                m_pend = 1;
            end
        end
        chk("psm_p", 32'(oPSM_P), 32'(ep));
        chk("psm_s", 32'(oPSM_S), 32'(es));
        chk("sync", 32'(oSYNC), 32'(esy));
        chk("err", 32'(oERR), 32'(eer));
        chk("pend", 32'(oPEND), 32'(m_pend));
        chk("dt", 32'(oDT), 32'(m_dt));
        if (oPSM_P === 1'b1 && !prev_p) begin
            lead = cyc - last_rise_s;
            last_rise_p = cyc;
        end
        if (oPSM_S === 1'b1 && !prev_s) begin
            lag = cyc - last_rise_p;
            last_rise_s = cyc;
        end
        if (oSYNC === 1'b1) begin
            sync_gap = cyc - last_sync;
            last_sync = cyc;
        end
        prev_p = (oPSM_P === 1'b1);
        prev_s = (oPSM_S === 1'b1);
    endtask

    task automatic idle_steps(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, en, 0, 0, 0, 0);
    endtask

    task automatic run_to_pos(input int pos);
        int guard;
        guard = 0;
        while (m_pos != pos && guard < 400) begin
            step(0, 1, 0, 0, 0, 0);
            guard++;
        end
        chk("reach_pos", 32'(m_pos), 32'(pos));
    endtask

    initial begin
        bit en_r;
        int per, ph;
        // reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle_steps(3, 0);

        // 1: P=100, phase 0, DT 5
        step(0, 0, 1, 100, 0, 5);
        idle_steps(260, 1);
        chk("t1_lag", 32'(lag), 32'd0);
        chk("t1_sync_gap", 32'(sync_gap), 32'd100);

        // 2: phase +20 then -20
        step(0, 1, 1, 100, 20, 6);
        idle_steps(250, 1);
        chk("t2_lag20", 32'(lag), 32'd20);
        step(0, 1, 1, 100, -20, 7);
        idle_steps(250, 1);
        chk("t2_lead20", 32'(lead), 32'd20);

        // 3: clamp +70 -> +49, then odd period 101 -> 100
        step(0, 1, 1, 100, 70, 8);
        idle_steps(250, 1);
        chk("t3_lag49", 32'(lag), 32'd49);
        step(0, 1, 1, 101, 0, 9);
        idle_steps(250, 1);
        chk("t3_sync_gap", 32'(sync_gap), 32'd100);

        // 4: rejected load
        step(0, 1, 1, 6, 10, 1);
        idle_steps(20, 1);

        // 5: two loads in one period, then a load coincident with the wrap
        run_to_pos(5);
        step(0, 1, 1, 100, 10, 10);
        idle_steps(5, 1);
        step(0, 1, 1, 100, 30, 11);
        run_to_pos(99);
        step(0, 1, 1, 100, 5, 12);
        idle_steps(60, 1);
        chk("t5_lag30", 32'(lag), 32'd30);
        idle_steps(150, 1);
        chk("t5_lag5", 32'(lag), 32'd5);

        // 6: reset mid-run, then enable drop at cnt=40
        run_to_pos(30);
        step(1, 1, 0, 0, 0, 0);
        idle_steps(20, 1);
        step(0, 1, 1, 64, 12, 13);
        idle_steps(80, 1);
        run_to_pos(40);
        idle_steps(100, 0);
        idle_steps(40, 1);

        // randomized traffic
        en_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) en_r = !en_r;
            per = int'($urandom_range(0, 70));
            if ($urandom_range(0, 1) == 0) ph = int'($urandom_range(0, 80)) - 40;
            else ph = int'($urandom_range(0, 4095));
            step($urandom_range(0, 1499) == 0, en_r, $urandom_range(0, 39) == 0,
                 per, ph, int'($urandom_range(0, 127)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
